alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencer that drives the existing combinational ALU register operator from the initiator side. It buffers ALU commands, fetches operands from a small internal register file, and presents instruction/A/B to the ALU. It captures the ALU result X, writes it back to the register file and reports completion. It replaces ad-hoc stimulus with a real issue path between the command source and the ALU.

Parameters:
DATA_W, 6, operand/result width (matches ALU A/B/X)
OP_W, 4, ALU instruction width
NREGS, 8, register-file entries; index width IDX_W = clog2(NREGS) = 3
FIFO_DEPTH, 4, command FIFO entries (power of 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_op  in  OP_W  ALU instruction
cmd_ra  in  IDX_W  source A register index
cmd_rb  in  IDX_W  source B register index
cmd_rd  in  IDX_W  destination register index
ld_en  in  1  direct register-file write strobe
ld_idx  in  IDX_W  direct write index
ld_data  in  DATA_W  direct write data
rd_idx  in  IDX_W  debug read index
rd_data  out  DATA_W  rf[rd_idx], combinational
alu_instruction  out  OP_W  to ALU instruction, registered
alu_a  out  DATA_W  to ALU A, registered
alu_b  out  DATA_W  to ALU B, registered
alu_x  in  DATA_W  from ALU X, combinational function of the three above
res_valid  out  1  one-cycle completion pulse
res_rd  out  IDX_W  destination of completed op
res_data  out  DATA_W  result written back
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, any time): FIFO empty; rf all zero; state IDLE; alu_instruction/alu_a/alu_b = 0; res_valid = 0; res_rd/res_data = 0. An in-flight op is dropped, with no writeback and no res_valid.
- Push: on any edge where cmd_valid && cmd_ready. cmd_ready = !full, registered-count based, so no push when full, even if a pop occurs in the same cycle.
- FSM IDLE -> EXEC: taken when FIFO non-empty. On that edge: pop the head; alu_instruction <= op; alu_a <= rf[ra]; alu_b <= rf[rb]; latch rd.
- FSM EXEC -> DONE: taken unconditionally. On that edge: rf[rd] <= alu_x; res_data <= alu_x; res_rd <= rd; res_valid <= 1.
- FSM DONE -> IDLE: taken unconditionally; res_valid <= 0.
- ALU outputs hold their last values outside EXEC.
- Timing: accept in cycle C0; pop edge ends C1; ALU ports valid in C2; res_valid high in C3 only; rd_data reflects the new value from C3.
- Throughput: one op per 3 cycles; FIFO absorbs bursts.
- Ordering: ops complete in command order.
- Read-after-write: writeback occurs before the next pop edge, so a dependent op always reads the new value. No bypass needed.
- ld_en and writeback on the same edge, same index: writeback wins. Different indices: both take effect.
- ld_en on a pop edge to a source index: the op reads the old value.
- Pop and push on the same edge: the FIFO count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- ra == rb and rd == ra are legal.

Decomposition:
- Package alu_pkg holds:
  - DATA_W, OP_W, IDX_W
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2)
  - named opcode constants 4'b0001 and 4'b0010, shared with the ALU
  - command struct {op, ra, rb, rd}, 13 bits
- Sub-module: cmd_fifo, a synchronous FIFO (width 13, depth FIFO_DEPTH, full/empty, async active-high reset).
- The register file and FSM stay in alu_issue_ctrl.
- The ALU stays external, connected through the alu_* ports.

Test Plan:
- Bench ALU model: X = A ^ B for op 0001, X = A & B for op 0010.
- Reset: assert rst mid-clock -> all outputs 0 immediately; after release cmd_ready=1, busy=0, rd_data=0 for every index.
- Basic op: load r1=001101, r2=010110; push op=0001 ra=1 rb=2 rd=3 in C0.
  - C2: alu_instruction=0001, alu_a=001101, alu_b=010110.
  - C3: res_valid=1, res_rd=3, res_data=011011; rd_data(rd_idx=3)=011011.
- Dependency: load r4=111111, r5=000000; push op=0001 rd=3 (r1,r2), then op=0010 ra=3 rb=4 rd=6 back-to-back -> second res_data=011011; r6=011011; r5 unchanged=000000.
- Back-pressure: push 8 commands on consecutive cycles with cmd_valid held.
  - cmd_ready must drop once the FIFO is full; no command is lost or duplicated.
  - Exactly 8 res_valid pulses in order, spaced 3 cycles apart.
- Write collision: ld_en idx=3 data=101010 in the same cycle as writeback to r3 of 011011 -> r3=011011.
- Reset mid-op: push a command, assert rst during EXEC (C2) -> no res_valid ever; rf all zero; after release, a fresh command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding, opcodes and command layout for the ALU issue path.
package alu_pkg;
    localparam int DATA_W     = 6;
    localparam int OP_W       = 4;
    localparam int NREGS      = 8;
    localparam int IDX_W      = $clog2(NREGS);
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [OP_W-1:0] OP_XOR = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] ra;
        logic [IDX_W-1:0] rb;
        logic [IDX_W-1:0] rd;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; full/empty derive from a registered occupancy count.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        full_s    = (count_q == CNT_W'(DEPTH));
        empty_s   = (count_q == {CNT_W{1'b0}});
        do_push_s = push_i && !full_s;
        do_pop_s  = pop_i && !empty_s;
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_s;
    assign empty_o = empty_s;
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer: buffers commands, reads operands from the register file,
// drives the external ALU and writes its result back.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [IDX_W-1:0]  cmd_ra,
    input  logic [IDX_W-1:0]  cmd_rb,
    input  logic [IDX_W-1:0]  cmd_rd,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [OP_W-1:0]   alu_instruction,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_x,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    state_e            state_q, state_d;
    cmd_t              cmd_in_s, head_s;
    logic              fifo_full_s, fifo_empty_s;
    logic              pop_s, wb_s;
    logic [IDX_W-1:0]  rd_q;
    logic [OP_W-1:0]   alu_instruction_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic              res_valid_q;
    logic [IDX_W-1:0]  res_rd_q;
    logic [DATA_W-1:0] res_data_q;

    // Pack the incoming command fields.
    always_comb begin
        cmd_in_s.op = cmd_op;
        cmd_in_s.ra = cmd_ra;
        cmd_in_s.rb = cmd_rb;
        cmd_in_s.rd = cmd_rd;
    end

    cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .data_i  (cmd_in_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Issue FSM next-state: pop when idle with work queued, write back from EXEC.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        wb_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_EXEC;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                wb_s    = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file next state; ALU writeback takes priority over a direct load.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (wb_s && (rd_q == IDX_W'(i))) begin
                rf_d[i] = alu_x;
            end else if (ld_en && (ld_idx == IDX_W'(i))) begin
                rf_d[i] = ld_data;
            end else begin
                rf_d[i] = rf_q[i];
            end
        end
    end

    // Register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // FSM state, ALU operand registers and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            rd_q              <= {IDX_W{1'b0}};
            alu_instruction_q <= {OP_W{1'b0}};
            alu_a_q           <= {DATA_W{1'b0}};
            alu_b_q           <= {DATA_W{1'b0}};
            res_valid_q       <= 1'b0;
            res_rd_q          <= {IDX_W{1'b0}};
            res_data_q        <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            res_valid_q <= wb_s;
            if (pop_s) begin
                alu_instruction_q <= head_s.op;
                alu_a_q           <= rf_q[head_s.ra];
                alu_b_q           <= rf_q[head_s.rb];
                rd_q              <= head_s.rd;
            end
            if (wb_s) begin
                res_rd_q   <= rd_q;
                res_data_q <= alu_x;
            end
        end
    end

    assign cmd_ready       = !fifo_full_s;
    assign rd_data         = rf_q[rd_idx];
    assign busy            = (state_q != ST_IDLE) || !fifo_empty_s;
    assign alu_instruction = alu_instruction_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign res_valid       = res_valid_q;
    assign res_rd          = res_rd_q;
    assign res_data        = res_data_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a result scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic              clk, rst;
    logic              cmd_valid, cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [IDX_W-1:0]  cmd_ra, cmd_rb, cmd_rd;
    logic              ld_en;
    logic [IDX_W-1:0]  ld_idx, rd_idx;
    logic [DATA_W-1:0] ld_data, rd_data;
    logic [OP_W-1:0]   alu_instruction;
    logic [DATA_W-1:0] alu_a, alu_b, alu_x;
    logic              res_valid;
    logic [IDX_W-1:0]  res_rd;
    logic [DATA_W-1:0] res_data;
    logic              busy;

    typedef struct {
        logic [IDX_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] m_rf [NREGS];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                pulses = 0;
    int                pulse_cyc[$];

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .alu_instruction(alu_instruction), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (op)
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            default: return 6'd0;
        endcase
    endfunction

    always_comb alu_x = alu_f(alu_instruction, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (res_valid === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_res_rd", 32'(res_rd), 32'(e.rd));
                check("sb_res_data", 32'(res_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
        ld_en = 1'b1; ld_idx = idx; ld_data = data;
        tick();
        ld_en = 1'b0;
        m_rf[idx] = data;
    endtask

    task automatic sb_expect(input logic [OP_W-1:0] op, input logic [IDX_W-1:0] ra,
                             input logic [IDX_W-1:0] rb, input logic [IDX_W-1:0] rd);
        exp_t e;
        e.rd = rd;
        e.data = alu_f(op, m_rf[ra], m_rf[rb]);
        m_rf[rd] = e.data;
        sb.push_back(e);
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [IDX_W-1:0] ra,
                        input logic [IDX_W-1:0] rb, input logic [IDX_W-1:0] rd);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        check("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        sb_expect(op, ra, rb, rd);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_rf_zero();
        for (int i = 0; i < NREGS; i++) begin
            rd_idx = IDX_W'(i);
            tick();
            check("rf_zero", 32'(rd_data), 32'd0);
        end
    endtask

    initial begin
        int k, stalls, guard, pb;
        logic [IDX_W-1:0] kk;
        logic [OP_W-1:0]  kop;
        logic             acc;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_rd = 3'd0;
        ld_en = 1'b0; ld_idx = 3'd0; ld_data = 6'd0; rd_idx = 3'd0;
        for (int i = 0; i < NREGS; i++) m_rf[i] = 6'd0;

        // Power-on reset.
        #2;
        check("por_res_valid", 32'(res_valid), 32'd0);
        check("por_alu_a", 32'(alu_a), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("por_cmd_ready", 32'(cmd_ready), 32'd1);
        check("por_busy", 32'(busy), 32'd0);
        check_rf_zero();

        // Basic op with exact cycle timing.
        ld(3'd1, 6'b001101);
        ld(3'd2, 6'b010110);
        rd_idx = 3'd3;
        push(OP_XOR, 3'd1, 3'd2, 3'd3);
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("c2_instr", 32'(alu_instruction), 32'(4'b0001));
        check("c2_alu_a", 32'(alu_a), 32'(6'b001101));
        check("c2_alu_b", 32'(alu_b), 32'(6'b010110));
        check("c2_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("c3_res_valid", 32'(res_valid), 32'd1);
        check("c3_res_rd", 32'(res_rd), 32'd3);
        check("c3_res_data", 32'(res_data), 32'(6'b011011));
        check("c3_rd_data", 32'(rd_data), 32'(6'b011011));
        tick();
        check("c4_res_valid", 32'(res_valid), 32'd0);
        check("c4_alu_hold", 32'(alu_a), 32'(6'b001101));

        // Asynchronous reset mid-clock clears outputs immediately.
        #2;
        rst = 1'b1;
        #1;
        check("arst_instr", 32'(alu_instruction), 32'd0);
        check("arst_alu_a", 32'(alu_a), 32'd0);
        check("arst_alu_b", 32'(alu_b), 32'd0);
        check("arst_res_rd", 32'(res_rd), 32'd0);
        check("arst_res_data", 32'(res_data), 32'd0);
        check("arst_rd_data", 32'(rd_data), 32'd0);
        for (int i = 0; i < NREGS; i++) m_rf[i] = 6'd0;
        tick();
        rst = 1'b0;

        // Dependent ops issued back-to-back.
        ld(3'd1, 6'b001101);
        ld(3'd2, 6'b010110);
        ld(3'd4, 6'b111111);
        ld(3'd5, 6'b000000);
        push(OP_XOR, 3'd1, 3'd2, 3'd3);
        push(OP_AND, 3'd3, 3'd4, 3'd6);
        drain();
        rd_idx = 3'd6; #1;
        check("dep_r6", 32'(rd_data), 32'(6'b011011));
        rd_idx = 3'd5; #1;
        check("dep_r5", 32'(rd_data), 32'(6'b000000));

        // Back-pressure burst of 8 with cmd_valid held.
        for (int i = 0; i < NREGS; i++) ld(IDX_W'(i), DATA_W'(i * 11 + 5));
        pb = pulses;
        pulse_cyc.delete();
        k = 0; stalls = 0; guard = 0;
        while (k < 8 && guard < 100) begin
            kk  = IDX_W'(k);
            kop = kk[0] ? OP_AND : OP_XOR;
            cmd_valid = 1'b1; cmd_op = kop; cmd_ra = kk; cmd_rb = kk + 3'd3; cmd_rd = kk + 3'd5;
            acc = cmd_ready;
            if (!acc) stalls++;
            tick();
            if (acc) begin
                sb_expect(kop, kk, kk + 3'd3, kk + 3'd5);
                k++;
            end
            guard++;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(k), 32'd8);
        check("bp_ready_dropped", 32'(stalls > 0), 32'd1);
        drain();
        check("bp_pulses", 32'(pulses - pb), 32'd8);
        for (int j = 1; j < pulse_cyc.size(); j++) begin
            check("bp_spacing", 32'(pulse_cyc[j] - pulse_cyc[j-1]), 32'd3);
        end

        // Load on pop edge reads old value; load colliding with writeback loses.
        ld(3'd1, 6'b001101);
        ld(3'd2, 6'b010110);
        push(OP_XOR, 3'd1, 3'd2, 3'd3);
        ld_en = 1'b1; ld_idx = 3'd1; ld_data = 6'b111000;
        tick();
        m_rf[1] = 6'b111000;
        check("popedge_alu_a", 32'(alu_a), 32'(6'b001101));
        ld_en = 1'b1; ld_idx = 3'd3; ld_data = 6'b101010;
        tick();
        ld_en = 1'b0;
        rd_idx = 3'd3; #1;
        check("collide_r3", 32'(rd_data), 32'(6'b011011));
        rd_idx = 3'd1; #1;
        check("popedge_r1", 32'(rd_data), 32'(6'b111000));
        drain();

        // Reset during EXEC drops the in-flight op.
        ld(3'd1, 6'b000111);
        ld(3'd2, 6'b000101);
        push(OP_XOR, 3'd1, 3'd2, 3'd7);
        tick();
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < NREGS; i++) m_rf[i] = 6'd0;
        #1;
        check("midop_res_valid", 32'(res_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midop_no_res", 32'(res_valid), 32'd0);
            check("midop_idle", 32'(busy), 32'd0);
        end
        check_rf_zero();
        ld(3'd1, 6'b000111);
        ld(3'd2, 6'b000101);
        push(OP_AND, 3'd1, 3'd2, 3'd0);
        drain();
        rd_idx = 3'd0; #1;
        check("fresh_r0", 32'(rd_data), 32'(6'b000101));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
